// File: rtl/stopwatch_timer_core_pkg.sv
// stopwatch_pkg: FSM states, BCD digit helpers and active-low 7-segment glyphs
package stopwatch_pkg;
  typedef enum logic [2:0] {IDLE, RUN_UP, RUN_DN, LOAD_WAIT, DONE_S, ERR_S} state_t;
  typedef logic [3:0] bcd_t;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_R = 7'h2F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  function automatic bcd_t digit_max(int i);
    return (i == 1 || i == 3) ? 4'd5 : 4'd9;
  endfunction
  function automatic bcd_t bcd_inc(bcd_t d, bcd_t lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction
  function automatic bcd_t bcd_dec(bcd_t d, bcd_t lim);
    return (d == 4'd0) ? lim : d - 4'd1;
  endfunction
  function automatic logic [6:0] seg_of(bcd_t d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/stopwatch_timer_core_if.sv
// stopwatch_timer_core_if: front-panel buttons in, display drive and status out (LAP with STOPWATCH_LAP_EN)
interface stopwatch_timer_core_if #(parameter int NUM_DIGITS = 4);
  logic clr, ml, ms, mm;
`ifdef STOPWATCH_LAP_EN
  logic lap;
`endif
  logic [7:0] seg7;
  logic [NUM_DIGITS-1:0] enseg;
  logic done, err;
`ifdef STOPWATCH_LAP_EN
  modport master (output clr, ml, ms, mm, lap, input seg7, enseg, done, err);
  modport slave (input clr, ml, ms, mm, lap, output seg7, enseg, done, err);
`else
  modport master (output clr, ml, ms, mm, input seg7, enseg, done, err);
  modport slave (input clr, ml, ms, mm, output seg7, enseg, done, err);
`endif
endinterface

// File: rtl/stopwatch_timer_core_seg7_scan_mux.sv
// seg7_scan_mux: digit scan counter, BCD/"Err" glyph decode and MM.SS decimal point, registered outputs
module seg7_scan_mux
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS*4-1:0] value,
  input  logic                    err_mode,
  output logic [7:0]              seg7,
  output logic [NUM_DIGITS-1:0]   enseg
);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [SW-1:0] sc;
  logic [DW-1:0] dg;
  logic [6:0] glyph;
  logic slot_end;
  assign slot_end = sc == SW'(SCAN_DIV - 1);
  assign glyph = err_mode ? (dg == DW'(3) ? SEG_E : (dg == DW'(2) || dg == DW'(1)) ? SEG_R : SEG_BLANK)
                          : seg_of(value[dg*4 +: 4]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sc <= '0;
      dg <= '0;
      seg7 <= '1;
      enseg <= '1;
    end else begin
      sc <= slot_end ? '0 : sc + 1'b1;
      dg <= slot_end ? (dg == DW'(NUM_DIGITS - 1) ? '0 : dg + 1'b1) : dg;
      seg7 <= {~(dg == DW'(2) && !err_mode), glyph};
      enseg <= ~(NUM_DIGITS'(1) << dg);
    end
endmodule

// File: rtl/stopwatch_timer_core.sv
// stopwatch_timer_core: up/down BCD stopwatch/countdown with synchronised buttons and multiplexed 7-seg drive
// Define STOPWATCH_LAP_EN to add the LAP input and the lap-hold display register.
module stopwatch_timer_core
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000,
  parameter logic [NUM_DIGITS*4-1:0] LOAD_VAL = 'h0500
) (
  input logic clk,
  input logic rst_n,
  stopwatch_timer_core_if.slave bus
);
  localparam int CW = NUM_DIGITS * 4;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
`ifdef STOPWATCH_LAP_EN
  localparam int NS = 4;
`else
  localparam int NS = 3;
`endif
  logic [NS-1:0] raw, s1, s2, pv;
  logic [1:0] cs;
  state_t state, nxt;
  logic [CW-1:0] count, cnt_nxt, cnt_inc, cnt_dec, shown;
  logic [PW-1:0] presc;
  logic run, tick, cy, bw, err_mode;
  logic clr_s, ml_s, ms_s, mm_s, ml_rise, ml_fall, ms_fall, mm_rise, mm_fall;
`ifdef STOPWATCH_LAP_EN
  assign raw = {bus.lap, bus.ml, bus.ms, bus.mm};
`else
  assign raw = {bus.ml, bus.ms, bus.mm};
`endif
  assign clr_s = cs[1];
  assign {ml_s, ms_s, mm_s} = s2[2:0];
  assign ml_rise = ml_s & ~pv[2];
  assign ml_fall = ~ml_s & pv[2];
  assign ms_fall = ~ms_s & pv[1];
  assign mm_rise = mm_s & ~pv[0];
  assign mm_fall = ~mm_s & pv[0];
  assign run = state == RUN_UP || state == RUN_DN;
  assign tick = run && presc == PW'(TICK_DIV - 1);
  assign err_mode = state == ERR_S;
  assign bus.done = state == DONE_S;
  assign bus.err = err_mode;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cs <= '0;
      s1 <= '0;
      s2 <= '0;
      pv <= '0;
      state <= IDLE;
      count <= '0;
      presc <= '0;
    end else begin
      cs <= {cs[0], bus.clr};
      s1 <= raw;
      s2 <= s1;
      pv <= s2;
      state <= nxt;
      count <= cnt_nxt;
      presc <= (run && !clr_s && !tick) ? presc + 1'b1 : '0;
    end
  // digit-wise carry/borrow; each digit wraps at its own limit (5 for tens of seconds/minutes)
  always_comb begin
    cnt_inc = count;
    cnt_dec = count;
    cy = 1'b1;
    bw = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cnt_inc[i*4 +: 4] = cy ? bcd_inc(count[i*4 +: 4], digit_max(i)) : count[i*4 +: 4];
      cnt_dec[i*4 +: 4] = bw ? bcd_dec(count[i*4 +: 4], digit_max(i)) : count[i*4 +: 4];
      cy = cy && count[i*4 +: 4] == digit_max(i);
      bw = bw && count[i*4 +: 4] == 4'd0;
    end
  end
  always_comb begin
    nxt = state;
    cnt_nxt = count;
    if (clr_s) begin
      nxt = IDLE;
      cnt_nxt = '0;
    end else
      case (state)
        IDLE:
          if (ms_s) nxt = !mm_s ? RUN_UP : (count == '0 ? DONE_S : RUN_DN);
          else if (ml_rise) nxt = LOAD_WAIT;
        RUN_UP:
          if (!ms_s) nxt = IDLE;
          else if (mm_rise) nxt = ERR_S;
          else if (tick) cnt_nxt = cnt_inc;
        RUN_DN:
          if (!ms_s) nxt = IDLE;
          else if (mm_fall) nxt = ERR_S;
          else if (tick && count != '0) begin
            cnt_nxt = cnt_dec;
            nxt = cnt_dec == '0 ? DONE_S : RUN_DN;
          end
        LOAD_WAIT:
          if (ml_fall) begin
            cnt_nxt = LOAD_VAL;
            nxt = IDLE;
          end
        DONE_S: begin
          cnt_nxt = '0;
          nxt = ms_fall ? IDLE : DONE_S;
        end
        default: nxt = ERR_S;
      endcase
  end
`ifdef STOPWATCH_LAP_EN
  logic lap_on, lap_rise;
  logic [CW-1:0] lap_val;
  assign lap_rise = s2[3] & ~pv[3];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lap_on <= 1'b0;
      lap_val <= '0;
    end else begin
      lap_on <= run && !clr_s && (lap_rise ? !lap_on : lap_on);
      lap_val <= (run && lap_rise && !lap_on) ? count : lap_val;
    end
  assign shown = lap_on ? lap_val : count;
`else
  assign shown = count;
`endif
  seg7_scan_mux #(.NUM_DIGITS(NUM_DIGITS), .SCAN_DIV(SCAN_DIV)) u_scan (
    .clk(clk),
    .rst_n(rst_n),
    .value(shown),
    .err_mode(err_mode),
    .seg7(bus.seg7),
    .enseg(bus.enseg)
  );
endmodule

// File: tb/tb_stopwatch_timer_core.sv
// tb_stopwatch_timer_core: directed checks of counting, load, countdown/done, error lockout and display scan
module tb_stopwatch_timer_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [31:0] disp;
  stopwatch_timer_core_if #(.NUM_DIGITS(4)) bus();
  stopwatch_timer_core #(.NUM_DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .LOAD_VAL(16'h0500)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic read_disp(output logic [31:0] o);
    o = 'x;
    repeat (16) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (bus.enseg === ~(4'b0001 << i)) o[i*8 +: 8] = bus.seg7;
    end
  endtask
  initial begin
    bus.clr = 0; bus.ml = 0; bus.ms = 0; bus.mm = 0;
`ifdef STOPWATCH_LAP_EN
    bus.lap = 0;
`endif
    cyc(3);
    chk("rst_seg7", bus.seg7, 8'hFF);
    chk("rst_enseg", bus.enseg, 4'hF);
    @(negedge clk) rst_n = 1;
    cyc(2);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    read_disp(disp);
    chk("rst_disp_0000", disp, 32'hC040C0C0);
    // count up: n-th tick lands 3+4n edges after MS is driven
    bus.ms = 1;
    cyc(963);
    chk("up_240_ticks", dut.count, 16'h0400);
    cyc(13436);
    chk("up_5959", dut.count, 16'h5959);
    cyc(4);
    chk("up_wrap_0000", dut.count, 16'h0000);
    chk("up_wrap_done", bus.done, 1'b0);
    cyc(4);
    chk("up_after_wrap", dut.count, 16'h0001);
    // MM rise while counting up locks into error
    bus.mm = 1;
    cyc(3);
    chk("err_set", bus.err, 1'b1);
    chk("err_frozen", dut.count, 16'h0001);
    bus.ms = 0; bus.ml = 1;
    cyc(6);
    chk("err_ignores_ms_ml", bus.err, 1'b1);
    read_disp(disp);
    chk("err_disp", disp, 32'h86AFAFFF);
    bus.ml = 0;
    cyc(4);
    chk("err_held", bus.err, 1'b1);
    bus.clr = 1;
    cyc(1);
    bus.clr = 0;
    cyc(2);
    chk("clr_err", bus.err, 1'b0);
    chk("clr_count", dut.count, 16'h0000);
    bus.mm = 0;
    // load on ML release, MS ignored while ML held
    bus.ml = 1;
    cyc(20);
    chk("load_hold", dut.count, 16'h0000);
    bus.ms = 1;
    cyc(5);
    chk("load_ms_ignored", dut.count, 16'h0000);
    bus.ms = 0;
    cyc(3);
    read_disp(disp);
    chk("load_hold_disp", disp, 32'hC040C0C0);
    bus.ml = 0;
    cyc(2);
    chk("load_not_yet", dut.count, 16'h0000);
    cyc(1);
    chk("load_0500", dut.count, 16'h0500);
    read_disp(disp);
    chk("load_disp", disp, 32'hC012C0C0);
    // countdown from 05:00
    bus.ms = 1; bus.mm = 1;
    cyc(7);
    chk("dn_0459", dut.count, 16'h0459);
    cyc(1192);
    chk("dn_0001", dut.count, 16'h0001);
    chk("dn_not_done", bus.done, 1'b0);
    cyc(4);
    chk("dn_0000", dut.count, 16'h0000);
    chk("dn_done", bus.done, 1'b1);
    cyc(20);
    chk("dn_stays_0", dut.count, 16'h0000);
    chk("dn_done_held", bus.done, 1'b1);
    bus.ms = 0; bus.mm = 0;
    cyc(3);
    chk("dn_done_clear", bus.done, 1'b0);
    // countdown requested at zero goes straight to done
    bus.ms = 1; bus.mm = 1;
    cyc(3);
    chk("zero_dn_done", bus.done, 1'b1);
    chk("zero_dn_err", bus.err, 1'b0);
    bus.ms = 0; bus.mm = 0;
    cyc(3);
    chk("zero_dn_exit", bus.done, 1'b0);
    // run then asynchronous reset mid-run
    bus.ms = 1;
    cyc(51);
    chk("run_0012", dut.count, 16'h0012);
`ifdef STOPWATCH_LAP_EN
    bus.lap = 1;
    cyc(32);
    chk("lap_live_0020", dut.count, 16'h0020);
    read_disp(disp);
    chk("lap_disp_0012", disp, 32'hC040F9A4);
    bus.lap = 0;
`endif
    #2 rst_n = 0;
    #1;
    chk("arst_seg7", bus.seg7, 8'hFF);
    chk("arst_enseg", bus.enseg, 4'hF);
    chk("arst_count", dut.count, 16'h0000);
    chk("arst_done_err", {bus.done, bus.err}, 2'b00);
    bus.ms = 0;
    @(negedge clk) rst_n = 1;
    cyc(2);
    read_disp(disp);
    chk("arst_disp", disp, 32'hC040C0C0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
